// File: rtl/mat_pkg.sv
// Shared types and constants for the 3x3 sliding-window generator.
package mat_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_FILL  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    // Line-buffer FIFO read data arrives this many cycles after rd_en.
    localparam int RD_LAT = 1;

    // Number of cycles the line buffers are held in reset at frame start.
    localparam int FLUSH_CYCLES = 2;

    // Window packing: {p11,p12,p13,p21,p22,p23,p31,p32,p33}, p11 in the MSBs;
    // row 1 is the oldest line, column 1 the leftmost pixel.
    localparam int WIN_TAPS   = 3;
    localparam int WIN_PIXELS = WIN_TAPS * WIN_TAPS;

endpackage

// File: rtl/mat_win_shift3.sv
// One window row: two stored columns plus the incoming pixel form the
// three taps, presented as they will be after the next enabled shift.
module mat_win_shift3
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] taps_next
);

    logic [DATA_WIDTH-1:0] tap_mid;
    logic [DATA_WIDTH-1:0] tap_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_mid <= '0;
            tap_old <= '0;
        end else if (en) begin
            tap_mid <= din;
            tap_old <= tap_mid;
        end
    end

    // Leftmost (oldest) column first, so the row packs straight into the window.
    assign taps_next = {tap_old, tap_mid, din};

endmodule

// File: rtl/mat_win3x3_gen.sv
// Builds a sliding 3x3 pixel window from a raster stream using two external
// cascaded line-buffer FIFOs (FIFO0 = previous line, FIFO1 = line before that).
module mat_win3x3_gen
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pix_vsync,
    input  logic                             pix_de,
    input  logic [DATA_WIDTH-1:0]            pix_data,
    output logic                             fifo_rst,
    output logic                             f0_wr_en,
    output logic                             f0_rd_en,
    output logic [DATA_WIDTH-1:0]            f0_wr_data,
    input  logic [DATA_WIDTH-1:0]            f0_rd_data,
    input  logic                             f0_full,
    input  logic                             f0_empty,
    output logic                             f1_wr_en,
    output logic                             f1_rd_en,
    output logic [DATA_WIDTH-1:0]            f1_wr_data,
    input  logic [DATA_WIDTH-1:0]            f1_rd_data,
    input  logic                             f1_full,
    input  logic                             f1_empty,
    output logic                             mat_vld,
    output logic [WIN_PIXELS*DATA_WIDTH-1:0] mat_data,
    output logic [1:0]                       err
);

    localparam logic [CNT_WIDTH-1:0] COL_LAST   = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST   = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [1:0]           FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   vsync_d;
    logic                   vsync_rise;
    logic                   accept;
    logic                   col_wrap;
    logic                   row_ge1;
    logic                   row_ge2;
    logic                   win_vld;
    logic                   fifo_rst_next;
    logic [1:0]             flush_cnt;
    logic [CNT_WIDTH-1:0]   col;
    logic [CNT_WIDTH-1:0]   row;

    logic [RD_LAT-1:0]                 acc_pipe;
    logic [RD_LAT-1:0]                 ge1_pipe;
    logic [RD_LAT-1:0]                 ge2_pipe;
    logic [RD_LAT-1:0]                 vld_pipe;
    logic [RD_LAT-1:0][DATA_WIDTH-1:0] pix_pipe;

    logic                            shift_en;
    logic [DATA_WIDTH-1:0]           row1_din;
    logic [DATA_WIDTH-1:0]           row2_din;
    logic [WIN_TAPS*DATA_WIDTH-1:0]  row1_taps;
    logic [WIN_TAPS*DATA_WIDTH-1:0]  row2_taps;
    logic [WIN_TAPS*DATA_WIDTH-1:0]  row3_taps;

    // A pixel arriving together with a frame-sync edge belongs to no frame.
    assign vsync_rise = pix_vsync & ~vsync_d;
    assign accept     = pix_de & ~vsync_rise & ((state == S_FILL) | (state == S_RUN));
    assign col_wrap   = (col == COL_LAST);
    assign row_ge1    = (row != '0);
    assign row_ge2    = (row >= CNT_WIDTH'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (vsync_rise) begin
            state_next = S_FLUSH;
        end else begin
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_FLUSH: if (flush_cnt == FLUSH_LAST) state_next = S_FILL;
                S_FILL:  if (accept && col_wrap && row == CNT_WIDTH'(1)) state_next = S_RUN;
                S_RUN:   if (accept && col_wrap && row == ROW_LAST) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FIFO0 receives every line; FIFO1 is fed from FIFO0's output one read later.
    always_comb begin
        fifo_rst_next = (state_next == S_FLUSH);
        f0_wr_en      = accept;
        f0_wr_data    = pix_data;
        f0_rd_en      = accept & row_ge1;
        f1_rd_en      = accept & row_ge2;
        f1_wr_en      = acc_pipe[RD_LAT-1] & ge1_pipe[RD_LAT-1];
        f1_wr_data    = f0_rd_data;
        win_vld       = accept & row_ge2 & (col >= CNT_WIDTH'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d  <= 1'b0;
            fifo_rst <= 1'b1;
        end else begin
            vsync_d  <= pix_vsync;
            fifo_rst <= fifo_rst_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
        end else if (vsync_rise) begin
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
        end else begin
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            if (accept) begin
                if (col_wrap) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + CNT_WIDTH'(1);
                end else begin
                    col <= col + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Delay the accepted pixel and its row context to meet the FIFO read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_pipe <= '0;
            ge1_pipe <= '0;
            ge2_pipe <= '0;
            vld_pipe <= '0;
            pix_pipe <= '0;
        end else begin
            acc_pipe[0] <= accept;
            ge1_pipe[0] <= row_ge1;
            ge2_pipe[0] <= row_ge2;
            vld_pipe[0] <= win_vld & ~vsync_rise;
            pix_pipe[0] <= pix_data;
            for (int i = 1; i < RD_LAT; i++) begin
                acc_pipe[i] <= acc_pipe[i-1];
                ge1_pipe[i] <= ge1_pipe[i-1];
                ge2_pipe[i] <= ge2_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1] & ~vsync_rise;
                pix_pipe[i] <= pix_pipe[i-1];
            end
        end
    end

    assign shift_en = acc_pipe[RD_LAT-1];
    assign row1_din = ge2_pipe[RD_LAT-1] ? f1_rd_data : '0;
    assign row2_din = ge1_pipe[RD_LAT-1] ? f0_rd_data : '0;

    mat_win_shift3 #(.DATA_WIDTH(DATA_WIDTH)) u_row1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (shift_en),
        .din       (row1_din),
        .taps_next (row1_taps)
    );

    mat_win_shift3 #(.DATA_WIDTH(DATA_WIDTH)) u_row2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (shift_en),
        .din       (row2_din),
        .taps_next (row2_taps)
    );

    mat_win_shift3 #(.DATA_WIDTH(DATA_WIDTH)) u_row3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (shift_en),
        .din       (pix_pipe[RD_LAT-1]),
        .taps_next (row3_taps)
    );

    // The window is captured only for valid positions so it holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_vld  <= 1'b0;
            mat_data <= '0;
        end else begin
            mat_vld <= vld_pipe[RD_LAT-1] & ~vsync_rise;
            if (vld_pipe[RD_LAT-1]) begin
                mat_data <= {row1_taps, row2_taps, row3_taps};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 2'b00;
        end else begin
            err[0] <= err[0] | (f0_rd_en & f0_empty) | (f1_rd_en & f1_empty);
            err[1] <= err[1] | (f0_wr_en & f0_full) | (f1_wr_en & f1_full);
        end
    end

endmodule

// File: tb/tb_mat_win3x3_gen.sv
// Scoreboard bench for mat_win3x3_gen on a 4x4 image with behavioural
// line-buffer FIFOs (one-cycle read latency).
module tb_mat_win3x3_gen;
    import mat_pkg::*;

    localparam int DW         = 8;
    localparam int W          = 4;
    localparam int H          = 4;
    localparam int FIFO_DEPTH = 16;

    typedef struct {
        logic [71:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_vsync = 1'b0;
    logic          pix_de = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          fifo_rst;
    logic          f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en;
    logic [DW-1:0] f0_wr_data, f1_wr_data;
    logic [DW-1:0] f0_rd_data = '0;
    logic [DW-1:0] f1_rd_data = '0;
    logic          f0_full, f0_empty, f1_full, f1_empty;
    logic          mat_vld;
    logic [71:0]   mat_data;
    logic [1:0]    err;

    logic [DW-1:0] f0_mem [$];
    logic [DW-1:0] f1_mem [$];
    int            f0_cnt = 0;
    int            f1_cnt = 0;
    logic          force_f0_empty = 1'b0;
    int            force_row = -1;

    exp_t exp_q [$];
    int   cyc = 0;
    int   win_count = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    mat_win3x3_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .CNT_WIDTH  (11)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_vsync  (pix_vsync),
        .pix_de     (pix_de),
        .pix_data   (pix_data),
        .fifo_rst   (fifo_rst),
        .f0_wr_en   (f0_wr_en),
        .f0_rd_en   (f0_rd_en),
        .f0_wr_data (f0_wr_data),
        .f0_rd_data (f0_rd_data),
        .f0_full    (f0_full),
        .f0_empty   (f0_empty),
        .f1_wr_en   (f1_wr_en),
        .f1_rd_en   (f1_rd_en),
        .f1_wr_data (f1_wr_data),
        .f1_rd_data (f1_rd_data),
        .f1_full    (f1_full),
        .f1_empty   (f1_empty),
        .mat_vld    (mat_vld),
        .mat_data   (mat_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous FIFOs standing in for the two line buffers.
    always @(posedge clk) begin
        if (fifo_rst) begin
            f0_mem.delete();
            f1_mem.delete();
        end else begin
            if (f0_rd_en && f0_mem.size() > 0) f0_rd_data <= f0_mem.pop_front();
            if (f0_wr_en && f0_mem.size() < FIFO_DEPTH) f0_mem.push_back(f0_wr_data);
            if (f1_rd_en && f1_mem.size() > 0) f1_rd_data <= f1_mem.pop_front();
            if (f1_wr_en && f1_mem.size() < FIFO_DEPTH) f1_mem.push_back(f1_wr_data);
        end
        f0_cnt <= f0_mem.size();
        f1_cnt <= f1_mem.size();
    end

    assign f0_empty = (f0_cnt == 0) | force_f0_empty;
    assign f1_empty = (f1_cnt == 0);
    assign f0_full  = (f0_cnt >= FIFO_DEPTH);
    assign f1_full  = (f1_cnt >= FIFO_DEPTH);

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    function automatic logic [71:0] win(input int r, input int c);
        return {pix(r-2, c-2), pix(r-2, c-1), pix(r-2, c),
                pix(r-1, c-2), pix(r-1, c-1), pix(r-1, c),
                pix(r,   c-2), pix(r,   c-1), pix(r,   c)};
    endfunction

    task automatic check_output(input string name, input logic [71:0] actual,
                                input logic [71:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every presented window is matched against the oldest expectation.
    always @(negedge clk) begin
        if (mat_vld === 1'b1) begin
            exp_t e;
            win_count++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_window: got %h, expected no window", mat_data);
            end else begin
                e = exp_q.pop_front();
                check_output("window_data", mat_data, e.data);
                check_output("window_latency", 72'(cyc), 72'(e.cyc + 2));
            end
        end
    end

    task automatic apply_stimulus(input int r, input int c, input int gap);
        exp_t e;
        repeat (gap) begin
            @(posedge clk); #1;
            pix_de = 1'b0;
        end
        @(posedge clk); #1;
        pix_de         = 1'b1;
        pix_data       = pix(r, c);
        force_f0_empty = (r == force_row);
        if (r >= 2 && c >= 2) begin
            e.data = win(r, c);
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    // Frame-sync pulse with a stray pixel in the same cycle; checks the flush.
    task automatic start_frame(input string name);
        int hi = 0;
        @(posedge clk); #1;
        pix_vsync = 1'b1;
        pix_de    = 1'b1;
        pix_data  = 8'hEE;
        win_count = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fifo_rst) hi++;
            if (i == 0) begin
                @(posedge clk); #1;
                pix_de = 1'b0;
            end
        end
        @(posedge clk); #1;
        pix_vsync = 1'b0;
        check_output({name, "_flush_cycles"}, 72'(hi), 72'(2));
        check_output({name, "_fifos_empty"}, 72'({f0_empty, f1_empty}), 72'(2'b11));
    endtask

    task automatic send_frame(input int max_gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                apply_stimulus(r, c, $urandom_range(0, max_gap));
    endtask

    task automatic end_frame(input string name);
        @(posedge clk); #1;
        pix_de         = 1'b0;
        force_row      = -1;
        force_f0_empty = 1'b0;
        repeat (4) @(negedge clk);
        check_output({name, "_windows"}, 72'(win_count), 72'(4));
        check_output({name, "_drained"}, 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_output("reset_mat_vld", 72'(mat_vld), 72'(0));
        check_output("reset_mat_data", mat_data, 72'(0));
        check_output("reset_fifo_rst", 72'(fifo_rst), 72'(1));
        check_output("reset_err", 72'(err), 72'(0));
        check_output("reset_state", 72'(dut.state), 72'(S_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle_fifo_rst", 72'(fifo_rst), 72'(0));

        start_frame("gapless");
        send_frame(0);
        end_frame("gapless");

        start_frame("gaps");
        send_frame(3);
        end_frame("gaps");

        start_frame("b2b");
        send_frame(0);
        end_frame("b2b");
        check_output("b2b_err", 72'(err), 72'(0));

        start_frame("abort");
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++)
                apply_stimulus(r, c, 0);
        apply_stimulus(2, 0, 0);
        apply_stimulus(2, 1, 0);
        start_frame("restart");
        send_frame(0);
        end_frame("restart");

        force_row = 2;
        start_frame("underflow");
        send_frame(0);
        end_frame("underflow");
        check_output("underflow_err", 72'(err), 72'(2'b01));
        start_frame("sticky");
        send_frame(0);
        end_frame("sticky");
        check_output("sticky_err", 72'(err), 72'(2'b01));

        start_frame("midreset");
        for (int c = 0; c < W; c++) apply_stimulus(0, c, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 1, 0);
        @(posedge clk); #1;
        pix_de = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("midreset_mat_vld", 72'(mat_vld), 72'(0));
        check_output("midreset_fifo_rst", 72'(fifo_rst), 72'(1));
        check_output("midreset_state", 72'(dut.state), 72'(S_IDLE));
        check_output("midreset_err", 72'(err), 72'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_frame("after_reset");
        send_frame(1);
        end_frame("after_reset");
        check_output("after_reset_err", 72'(err), 72'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
